// File: rtl/bank_read_arbiter_pkg.sv
// rtl/bank_read_arbiter_pkg.sv - shared meduram constants and index/counter helpers
package bank_read_arbiter_pkg;

  localparam int unsigned BANK_IDX_W = 3;

  function automatic int unsigned rot_idx(input int unsigned i, input int unsigned k,
                                          input int unsigned n);
    return (i + k) % n;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/bank_read_arbiter_rr_wait_counter.sv
// rtl/bank_read_arbiter_rr_wait_counter.sv - per-agent denial counter raising urgency at MAX_WAIT
module rr_wait_counter
  import bank_read_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic req,
  input  logic grant,
  input  logic deny,
  output logic urgent
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req || grant) begin
      wait_cnt_d = '0;
    end else if (deny) begin
      wait_cnt_d = WAIT_W'(sat_inc(32'(wait_cnt_q), MAX_WAIT));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign urgent = (MAX_WAIT > 0) && (wait_cnt_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/bank_read_arbiter.sv
// rtl/bank_read_arbiter.sv - two-pass rotating bank arbiter for N read agents with write priority
module bank_read_arbiter
  import bank_read_arbiter_pkg::*;
#(
  parameter int unsigned NB_RDAGENT      = 4,
  parameter int unsigned SELECT_WIDTH    = 4,
  parameter int unsigned SELECT_RANGE    = BANK_IDX_W,
  parameter bit          WRITE_COLLISION = 1'b1,
  parameter int unsigned MAX_WAIT        = 7,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NB_RDAGENT-1:0]              rd_req,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rd_bank,
  input  logic                               wr_en,
  input  logic [SELECT_WIDTH-1:0]            wr_bank,
  input  logic                               cnt_clear,
  output logic [NB_RDAGENT-1:0]              rd_grant,
  output logic [NB_RDAGENT-1:0]              rd_collision,
  output logic                               collision,
  output logic [CNT_WIDTH-1:0]               collision_cnt
);

  localparam int unsigned NB_BANK = 1 << SELECT_RANGE;
  localparam int unsigned PTR_W   = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;

  logic [NB_RDAGENT-1:0]   eligible;
  logic [NB_RDAGENT-1:0]   urgent;
  logic [NB_RDAGENT-1:0]   grant_d, grant_q;
  logic [NB_RDAGENT-1:0]   deny_d, deny_q;
  logic [PTR_W-1:0]        rr_ptr_d, rr_ptr_q;
  logic [CNT_WIDTH-1:0]    collision_cnt_d, collision_cnt_q;
  logic [NB_BANK-1:0]      claimed;
  logic                    first_found;
  int unsigned             idx;
  logic [SELECT_RANGE-1:0] bank;
  logic                    unused_bits;

  // An agent whose grant is still visible has been served and sits this cycle out.
  assign eligible = rd_req & ~grant_q;

  always_comb begin
    claimed     = '0;
    grant_d     = '0;
    deny_d      = '0;
    first_found = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    idx         = 0;
    bank        = '0;
    if (WRITE_COLLISION && wr_en) begin
      claimed[wr_bank[SELECT_RANGE-1:0]] = 1'b1;
    end
    // Pass 0 serves urgent agents, pass 1 the rest, both in the same rotated order.
    for (int pass = 0; pass < 2; pass++) begin
      for (int unsigned k = 0; k < NB_RDAGENT; k++) begin
        idx = rot_idx(32'(rr_ptr_q), k, NB_RDAGENT);
        if (eligible[idx] && (urgent[idx] == (pass == 0))) begin
          bank = rd_bank[idx*SELECT_WIDTH +: SELECT_RANGE];
          if (!claimed[bank]) begin
            claimed[bank] = 1'b1;
            grant_d[idx]  = 1'b1;
            if (!first_found) begin
              first_found = 1'b1;
              rr_ptr_d    = PTR_W'(rot_idx(idx, 1, NB_RDAGENT));
            end
          end else begin
            deny_d[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    collision_cnt_d = collision_cnt_q;
    if (cnt_clear) begin
      collision_cnt_d = '0;
    end else if (|deny_d) begin
      collision_cnt_d = CNT_WIDTH'(sat_inc(32'(collision_cnt_q), 32'({CNT_WIDTH{1'b1}})));
    end
  end

  for (genvar g = 0; g < NB_RDAGENT; g++) begin : g_wait
    rr_wait_counter #(
      .MAX_WAIT(MAX_WAIT)
    ) u_wait (
      .aclk   (aclk),
      .aresetn(aresetn),
      .req    (rd_req[g]),
      .grant  (grant_d[g]),
      .deny   (deny_d[g]),
      .urgent (urgent[g])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q         <= '0;
      deny_q          <= '0;
      rr_ptr_q        <= '0;
      collision_cnt_q <= '0;
    end else begin
      grant_q         <= grant_d;
      deny_q          <= deny_d;
      rr_ptr_q        <= rr_ptr_d;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign rd_grant      = grant_q;
  assign rd_collision  = deny_q;
  assign collision     = |deny_q;
  assign collision_cnt = collision_cnt_q;

  // Select bits above SELECT_RANGE carry no bank information.
  assign unused_bits = ^{wr_en, wr_bank, rd_bank};

endmodule

// File: tb/tb_bank_read_arbiter.sv
// tb/tb_bank_read_arbiter.sv - scoreboard bench for bank_read_arbiter
`timescale 1ns/1ps
module tb_bank_read_arbiter;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [3:0]  req0, wr_bank0, grant0, coll0;
  logic [15:0] bank0, cnt0;
  logic        wr_en0, clr0, collision0;

  logic [3:0]  req1, wr_bank1, grant1, coll1, cnt1;
  logic [15:0] bank1;
  logic        wr_en1, clr1, collision1;

  bank_read_arbiter #(
    .NB_RDAGENT(4), .SELECT_WIDTH(4), .SELECT_RANGE(3),
    .WRITE_COLLISION(1'b1), .MAX_WAIT(7), .CNT_WIDTH(16)
  ) dut0 (
    .aclk(aclk), .aresetn(aresetn), .rd_req(req0), .rd_bank(bank0),
    .wr_en(wr_en0), .wr_bank(wr_bank0), .cnt_clear(clr0),
    .rd_grant(grant0), .rd_collision(coll0), .collision(collision0),
    .collision_cnt(cnt0)
  );

  bank_read_arbiter #(
    .NB_RDAGENT(4), .SELECT_WIDTH(4), .SELECT_RANGE(3),
    .WRITE_COLLISION(1'b0), .MAX_WAIT(2), .CNT_WIDTH(4)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .rd_req(req1), .rd_bank(bank1),
    .wr_en(wr_en1), .wr_bank(wr_bank1), .cnt_clear(clr1),
    .rd_grant(grant1), .rd_collision(coll1), .collision(collision1),
    .collision_cnt(cnt1)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [3:0]  grant;
    logic [3:0]  coll;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Three agents hammering bank 0 on the MAX_WAIT=2, 4-bit counter instance.
  localparam logic [3:0] ST_G [20] = '{4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8,
                                       4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1};
  localparam logic [3:0] ST_C [20] = '{4'h3, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1,
                                       4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h2};
  localparam logic [3:0] ST_N [20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                       4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd1};

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endfunction

  task automatic expect_out(input int dut, input logic [3:0] g, input logic [3:0] c,
                            input logic [15:0] n);
    exp_t e;
    e.cyc   = cyc + 1;
    e.dut   = dut;
    e.grant = g;
    e.coll  = c;
    e.cnt   = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.dut == 0) begin
        chk($sformatf("c%0d_d0_grant", cyc), 32'(grant0), 32'(mon_e.grant));
        chk($sformatf("c%0d_d0_coll", cyc), 32'(coll0), 32'(mon_e.coll));
        chk($sformatf("c%0d_d0_collision", cyc), 32'(collision0), 32'(|mon_e.coll));
        chk($sformatf("c%0d_d0_cnt", cyc), 32'(cnt0), 32'(mon_e.cnt));
      end else begin
        chk($sformatf("c%0d_d1_grant", cyc), 32'(grant1), 32'(mon_e.grant));
        chk($sformatf("c%0d_d1_coll", cyc), 32'(coll1), 32'(mon_e.coll));
        chk($sformatf("c%0d_d1_collision", cyc), 32'(collision1), 32'(|mon_e.coll));
        chk($sformatf("c%0d_d1_cnt", cyc), 32'(cnt1), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    req0 = 4'b1111; bank0 = 16'h3210; wr_en0 = 1'b0; wr_bank0 = 4'd0; clr0 = 1'b0;
    req1 = 4'b0000; bank1 = 16'h0000; wr_en1 = 1'b0; wr_bank1 = 4'd0; clr1 = 1'b0;
    tick();
    tick();
    expect_out(0, 4'b0000, 4'b0000, 16'd0);
    tick();
    aresetn = 1'b1;
    expect_out(0, 4'b1111, 4'b0000, 16'd0);
    tick();
    req0 = 4'b0000;
    expect_out(0, 4'b0000, 4'b0000, 16'd0);
    tick();
    // Grant agent 3 alone so the pointer wraps back to 0.
    req0 = 4'b1000;
    expect_out(0, 4'b1000, 4'b0000, 16'd0);
    tick();
    req0 = 4'b0101; bank0 = 16'h0505;
    expect_out(0, 4'b0001, 4'b0100, 16'd1);
    tick();
    req0 = 4'b0100;
    expect_out(0, 4'b0100, 4'b0000, 16'd1);
    tick();
    req0 = 4'b0000;
    expect_out(0, 4'b0000, 4'b0000, 16'd1);
    tick();
    // Write holds bank 3 for 7 cycles; agent 1 becomes urgent and beats agent 0.
    wr_en0 = 1'b1; wr_bank0 = 4'd3; req0 = 4'b0010; bank0 = 16'h0030;
    for (int k = 0; k < 7; k++) begin
      expect_out(0, 4'b0000, 4'b0010, 16'(2 + k));
      tick();
    end
    wr_en0 = 1'b0; req0 = 4'b0011; bank0 = 16'h0033;
    expect_out(0, 4'b0010, 4'b0001, 16'd9);
    tick();
    req0 = 4'b0001;
    expect_out(0, 4'b0001, 4'b0000, 16'd9);
    tick();
    req0 = 4'b0000;
    expect_out(0, 4'b0000, 4'b0000, 16'd9);
    tick();
    req0 = 4'b1111; bank0 = 16'h3210;
    expect_out(0, 4'b1111, 4'b0000, 16'd9);
    tick();
    #6;
    aresetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant0), 32'd0);
    chk("async_rst_coll", 32'(coll0), 32'd0);
    chk("async_rst_collision", 32'(collision0), 32'd0);
    chk("async_rst_cnt", 32'(cnt0), 32'd0);
    expect_out(0, 4'b0000, 4'b0000, 16'd0);
    tick();
    aresetn = 1'b1; bank0 = 16'h1111;
    expect_out(0, 4'b0001, 4'b1110, 16'd1);
    tick();
    req0 = 4'b0000;
    expect_out(0, 4'b0000, 4'b0000, 16'd1);
    tick();
    // Write is ignored on the instance without write collision.
    wr_en1 = 1'b1; wr_bank1 = 4'd3; req1 = 4'b0010; bank1 = 16'h0030;
    expect_out(1, 4'b0010, 4'b0000, 16'd0);
    tick();
    wr_en1 = 1'b0; req1 = 4'b0000;
    expect_out(1, 4'b0000, 4'b0000, 16'd0);
    tick();
    req1 = 4'b1011; bank1 = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      clr1 = (k == 18);
      expect_out(1, ST_G[k], ST_C[k], 16'(ST_N[k]));
      tick();
    end
    req1 = 4'b0000; clr1 = 1'b0;
    expect_out(1, 4'b0000, 4'b0000, 16'd1);
    tick();
    tick();
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bank_read_arbiter.md
# bank_read_arbiter

Parametrised read-side bank arbiter for the multi-port banked RAM. It sits between N read agents and the bank array, in the same place as the read-collision detector. It arbitrates any number of readers that target the same bank, lets an optional write port take priority, and prevents starvation with per-agent wait counters. Grants, collision flags and a collision statistics counter are all registered.

## Interface
- NB_RDAGENT, 4, number of read agents (1..16)
- SELECT_WIDTH, 4, bank-select field width per agent
- SELECT_RANGE, 3, low bits of the select field that identify a bank (SELECT_RANGE <= SELECT_WIDTH)
- WRITE_COLLISION, 1, 1: an active write blocks readers of the same bank; 0: writes ignored
- MAX_WAIT, 7, cycles a request may be denied before it becomes urgent; 0 disables urgency
- CNT_WIDTH, 16, collision statistics counter width
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- rd_req  in  NB_RDAGENT  per-agent read request, held until granted
- rd_bank  in  NB_RDAGENT*SELECT_WIDTH  per-agent bank select; agent i uses bits [i*SELECT_WIDTH +: SELECT_RANGE]
- wr_en  in  1  write active this cycle
- wr_bank  in  SELECT_WIDTH  write bank select; low SELECT_RANGE bits are used
- cnt_clear  in  1  synchronous clear of collision_cnt
- rd_grant  out  NB_RDAGENT  registered one-cycle grant pulse per agent
- rd_collision  out  NB_RDAGENT  registered; agent i was denied in the previous cycle
- collision  out  1  OR of rd_collision
- collision_cnt  out  CNT_WIDTH  saturating count of arbitration cycles with at least one denial

## Operation
- Eligible set at cycle t: rd_req[i]=1 and rd_grant[i]=0. An agent whose grant is visible this cycle is consumed and excluded.
- Bank claim order:
  - A write claims wr_bank first when WRITE_COLLISION=1 and wr_en=1.
  - Pass 1: urgent eligible agents (wait_cnt==MAX_WAIT, MAX_WAIT>0), visited i = rr_ptr, rr_ptr+1, ... modulo NB_RDAGENT.
  - Pass 2: remaining eligible agents, visited in the same rotating order.
  - An agent is granted if its bank is still unclaimed; it then claims that bank. Otherwise it is denied.
- rr_ptr: if at least one agent is granted, it becomes (first granted agent in visit order + 1) mod NB_RDAGENT. Otherwise it is unchanged.
- wait_cnt[i]:
  - Cleared when the agent is granted or rd_req[i]=0.
  - Incremented when the agent is eligible and denied, saturating at MAX_WAIT.
  - Width is $clog2(MAX_WAIT+1), minimum 1.
- collision_cnt:
  - +1 per cycle in which any agent is denied, saturating at all-ones.
  - cnt_clear has priority and loads 0; a denial in the same cycle is not counted.
- NB_RDAGENT=1: readers never collide with each other; only a write can cause a denial.
- A change of rd_bank while rd_req is held is a protocol violation; the bank is re-evaluated each cycle with no error flag.

## Timing
- Reset (async assert, sync release): rd_grant=0, rd_collision=0, collision=0, collision_cnt=0, rr_ptr=0, all wait_cnt=0.
- Latency: request sampled at t produces a grant or collision flag at t+1.
- Throughput: at most one grant every 2 cycles per agent, because of the exclusion rule. Up to 2^SELECT_RANGE grants per cycle in total.
- rd_grant and rd_collision are mutually exclusive per agent.
- The write has no handshake and is never stalled.
- Bound on denial: with MAX_WAIT>0 and at most one urgent agent per bank, a held request is granted within MAX_WAIT+NB_RDAGENT cycles.

## Structure
- The shared meduram package holds:
  - bank index width constant
  - rotating-index function (i + k) mod N
  - saturating-increment function
- Sub-module rr_wait_counter: one instance per agent, holding wait_cnt and the urgent flag.
- The top level holds the two-pass claim loop, rr_ptr, output registers and the statistics counter.

## Test plan
- Reset with rd_req=4'b1111 on distinct banks 0..3 -> one cycle after release, rd_grant=4'b1111, collision=0.
- NB_RDAGENT=4, agents 0 and 2 both request bank 5, rr_ptr=0 -> rd_grant=4'b0001 and rd_collision=4'b0100. Two cycles later rd_grant=4'b0100. collision_cnt=1.
- WRITE_COLLISION=1, wr_en=1, wr_bank=3, agent 1 requests bank 3 -> rd_collision[1]=1. Grant comes the cycle after wr_en drops. With WRITE_COLLISION=0 the grant is immediate.
- MAX_WAIT=2: agents 0, 1 and 3 request bank 0 continuously and re-request right after each grant. Each denied agent reaches urgency after 2 denials -> no agent is denied more than MAX_WAIT+NB_RDAGENT consecutive eligible cycles.
- collision_cnt at 16'hFFFF with a further denial -> stays 16'hFFFF. Then cnt_clear=1 together with a denial -> 0.
- aresetn pulsed low mid-stream while grants are pending -> all outputs 0 asynchronously. After release, arbitration restarts from rr_ptr=0.
